// File: rtl/bus_sequencer.sv
// Multi-cycle transfer controller for the shared 32-bit datapath bus.
// Accepts one move/ALU command at a time and sequences one-hot bus drivers and load enables.
module bus_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_alu,
  input  logic        cmd_wide,
  input  logic [4:0]  cmd_src,
  input  logic [4:0]  cmd_src2,
  input  logic [4:0]  cmd_dst,
  input  logic [4:0]  cmd_op,
  input  logic        hold,
  output logic [23:0] src_oe,
  output logic [23:0] dst_ld,
  output logic        y_ld,
  output logic        z_ld,
  output logic [4:0]  alu_op,
  output logic        done,
  output logic        err
);

  localparam logic [4:0] CodeHi    = 5'd16;
  localparam logic [4:0] CodeLo    = 5'd17;
  localparam logic [4:0] CodeZhigh = 5'd18;
  localparam logic [4:0] CodeZlow  = 5'd19;
  localparam logic [4:0] CodePc    = 5'd20;
  localparam logic [4:0] CodeMdr   = 5'd21;
  localparam logic [4:0] CodeMax   = 5'd23;

  typedef enum logic [2:0] {StIdle, StMov, StA1, StA2, StA3, StA4} state_e;

  state_e     state_q, state_d;
  logic       ready_q;
  logic       err_q, err_d;
  logic       alu_q, wide_q;
  logic [4:0] src_q, src2_q, dst_q, op_q;

  logic accept;
  logic src_ok, src2_ok, dst_ok, legal;

  // Codes above 23 shift out of the 24-bit vector, so an illegal code never drives the bus.
  function automatic logic [23:0] dec(input logic [4:0] code);
    dec = 24'd1 << code;
  endfunction

  assign accept  = cmd_valid & cmd_ready;
  assign src_ok  = cmd_src <= CodeMax;
  assign src2_ok = ~cmd_alu | (cmd_src2 <= CodeMax);
  // Wide ALU results always land in HI/LO, so the destination field is unused.
  assign dst_ok  = (cmd_alu & cmd_wide) | (cmd_dst <= CodeLo) |
                   (cmd_dst == CodePc) | (cmd_dst == CodeMdr);
  assign legal   = src_ok & src2_ok & dst_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      alu_q   <= 1'b0;
      wide_q  <= 1'b0;
      src_q   <= 5'd0;
      src2_q  <= 5'd0;
      dst_q   <= 5'd0;
      op_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      err_q   <= err_d;
      if (accept) begin
        alu_q  <= cmd_alu;
        wide_q <= cmd_alu & cmd_wide;
        src_q  <= cmd_src;
        src2_q <= cmd_src2;
        dst_q  <= cmd_dst;
        op_q   <= cmd_op;
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            state_d = cmd_alu ? StA1 : StMov;
          end
        end
      end
      StMov: if (!hold) state_d = StIdle;
      StA1:  if (!hold) state_d = StA2;
      StA2:  if (!hold) state_d = StA3;
      StA3:  if (!hold) state_d = wide_q ? StA4 : StIdle;
      StA4:  if (!hold) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and latched command; hold freezes them by freezing state.
  always_comb begin
    cmd_ready = ready_q & (state_q == StIdle);
    src_oe    = 24'd0;
    dst_ld    = 24'd0;
    y_ld      = 1'b0;
    z_ld      = 1'b0;
    alu_op    = 5'd0;
    done      = 1'b0;
    err       = err_q;
    case (state_q)
      StMov: begin
        src_oe = dec(src_q);
        dst_ld = dec(dst_q);
        done   = 1'b1;
      end
      StA1: begin
        src_oe = dec(src_q);
        y_ld   = 1'b1;
      end
      StA2: begin
        src_oe = dec(src2_q);
        z_ld   = 1'b1;
        alu_op = op_q;
      end
      StA3: begin
        src_oe = dec(CodeZlow);
        if (wide_q) begin
          dst_ld = dec(CodeLo);
        end else begin
          dst_ld = dec(dst_q);
          done   = 1'b1;
        end
      end
      StA4: begin
        src_oe = dec(CodeZhigh);
        dst_ld = dec(CodeHi);
        done   = 1'b1;
      end
      default: ;
    endcase
  end

  logic unused_alu;
  assign unused_alu = alu_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed self-checking bench for bus_sequencer: reset, moves, ALU/wide transfers,
// illegal commands, hold stalls and mid-command reset.
module tb_bus_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_alu;
  logic        cmd_wide;
  logic [4:0]  cmd_src;
  logic [4:0]  cmd_src2;
  logic [4:0]  cmd_dst;
  logic [4:0]  cmd_op;
  logic        hold;
  logic [23:0] src_oe;
  logic [23:0] dst_ld;
  logic        y_ld;
  logic        z_ld;
  logic [4:0]  alu_op;
  logic        done;
  logic        err;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  bus_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_alu  (cmd_alu),
    .cmd_wide (cmd_wide),
    .cmd_src  (cmd_src),
    .cmd_src2 (cmd_src2),
    .cmd_dst  (cmd_dst),
    .cmd_op   (cmd_op),
    .hold     (hold),
    .src_oe   (src_oe),
    .dst_ld   (dst_ld),
    .y_ld     (y_ld),
    .z_ld     (z_ld),
    .alu_op   (alu_op),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks every output of the current step.
  task automatic step(input string tag, input logic [23:0] s, input logic [23:0] d,
                      input logic y, input logic z, input logic [4:0] op, input logic dn,
                      input logic rdy);
    check({tag, ".src_oe"}, 32'(src_oe), 32'(s));
    check({tag, ".dst_ld"}, 32'(dst_ld), 32'(d));
    check({tag, ".y_ld"}, 32'(y_ld), 32'(y));
    check({tag, ".z_ld"}, 32'(z_ld), 32'(z));
    check({tag, ".alu_op"}, 32'(alu_op), 32'(op));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".ready"}, 32'(cmd_ready), 32'(rdy));
    check({tag, ".err"}, 32'(err), 32'(0));
  endtask

  // Presents a command in a ready cycle; returns in cycle k+1.
  task automatic issue(input logic alu, input logic wide, input logic [4:0] s,
                       input logic [4:0] s2, input logic [4:0] d, input logic [4:0] op);
    check("ready_pre", 32'(cmd_ready), 32'(1));
    cmd_alu   = alu;
    cmd_wide  = wide;
    cmd_src   = s;
    cmd_src2  = s2;
    cmd_dst   = d;
    cmd_op    = op;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    check("src_onehot", 32'($onehot0(src_oe)), 32'(1));
    check("dst_onehot", 32'($onehot0(dst_ld)), 32'(1));
    if (done) n_done++;
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_alu = 1'b0; cmd_wide = 1'b0;
    cmd_src = 5'd0; cmd_src2 = 5'd0; cmd_dst = 5'd0; cmd_op = 5'd0; hold = 1'b0;
    #3;
    step("reset", 24'h0, 24'h0, 0, 0, 5'd0, 0, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    check("ready_at_release", 32'(cmd_ready), 32'(0));
    tick();
    check("ready_after_release", 32'(cmd_ready), 32'(1));

    // MOV R3 -> MDR
    n_done = 0;
    issue(0, 0, 5'd3, 5'd0, 5'd21, 5'd0);
    step("mov", 24'h000008, 24'h200000, 0, 0, 5'd0, 1, 0);
    tick();
    step("mov_idle", 24'h0, 24'h0, 0, 0, 5'd0, 0, 1);

    // ALU R2 op R5 -> R7
    issue(1, 0, 5'd2, 5'd5, 5'd7, 5'd3);
    step("alu_a1", 24'h000004, 24'h0, 1, 0, 5'd0, 0, 0);
    tick();
    step("alu_a2", 24'h000020, 24'h0, 0, 1, 5'd3, 0, 0);
    tick();
    step("alu_a3", 24'h080000, 24'h000080, 0, 0, 5'd0, 1, 0);
    tick();
    step("alu_idle", 24'h0, 24'h0, 0, 0, 5'd0, 0, 1);

    // Wide ALU; dst 31 is ignored and must not be rejected
    issue(1, 1, 5'd1, 5'd4, 5'd31, 5'd5);
    step("wide_a1", 24'h000002, 24'h0, 1, 0, 5'd0, 0, 0);
    tick();
    step("wide_a2", 24'h000010, 24'h0, 0, 1, 5'd5, 0, 0);
    tick();
    step("wide_a3", 24'h080000, 24'h020000, 0, 0, 5'd0, 0, 0);
    tick();
    step("wide_a4", 24'h040000, 24'h010000, 0, 0, 5'd0, 1, 0);
    tick();
    step("wide_idle", 24'h0, 24'h0, 0, 0, 5'd0, 0, 1);
    check("done_count_3cmds", 32'(n_done), 32'(3));

    // Illegal MOV dst = Zlow
    n_done = 0;
    issue(0, 0, 5'd3, 5'd0, 5'd19, 5'd0);
    check("ill_dst.err", 32'(err), 32'(1));
    check("ill_dst.src_oe", 32'(src_oe), 32'(0));
    check("ill_dst.dst_ld", 32'(dst_ld), 32'(0));
    check("ill_dst.ready", 32'(cmd_ready), 32'(1));
    tick();
    check("ill_dst.err_clr", 32'(err), 32'(0));

    // Illegal ALU operand B = 25
    issue(1, 0, 5'd2, 5'd25, 5'd7, 5'd1);
    check("ill_src2.err", 32'(err), 32'(1));
    check("ill_src2.y_ld", 32'(y_ld), 32'(0));
    tick();
    check("ill_done_none", 32'(n_done), 32'(0));

    // Next command accepted normally: MOV C -> R0 (highest source code)
    issue(0, 0, 5'd23, 5'd0, 5'd0, 5'd0);
    step("mov_c_r0", 24'h800000, 24'h000001, 0, 0, 5'd0, 1, 0);
    tick();

    // MOV src == dst
    issue(0, 0, 5'd5, 5'd0, 5'd5, 5'd0);
    step("mov_same", 24'h000020, 24'h000020, 0, 0, 5'd0, 1, 0);
    tick();

    // Hold for 3 cycles during A2, dst = PC
    n_done = 0;
    issue(1, 0, 5'd6, 5'd9, 5'd20, 5'h11);
    step("hold_a1", 24'h000040, 24'h0, 1, 0, 5'd0, 0, 0);
    tick();
    step("hold_a2_0", 24'h000200, 24'h0, 0, 1, 5'h11, 0, 0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      step("hold_a2_n", 24'h000200, 24'h0, 0, 1, 5'h11, 0, 0);
    end
    hold = 1'b0;
    tick();
    step("hold_a3", 24'h080000, 24'h100000, 0, 0, 5'd0, 1, 0);
    tick();
    step("hold_idle", 24'h0, 24'h0, 0, 0, 5'd0, 0, 1);
    check("hold_done_once", 32'(n_done), 32'(1));

    // Reset mid-A2 aborts immediately
    n_done = 0;
    issue(1, 0, 5'd2, 5'd5, 5'd7, 5'd3);
    tick();
    check("rst_pre.z_ld", 32'(z_ld), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    step("rst_mid", 24'h0, 24'h0, 0, 0, 5'd0, 0, 0);
    tick();
    rst_n = 1'b1;
    check("rst_rel.ready", 32'(cmd_ready), 32'(0));
    tick();
    check("rst_rel.ready_1", 32'(cmd_ready), 32'(1));
    check("rst_no_done", 32'(n_done), 32'(0));
    issue(0, 0, 5'd16, 5'd0, 5'd17, 5'd0);
    step("mov_hi_lo", 24'h010000, 24'h020000, 0, 0, 5'd0, 1, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Multi-cycle transfer controller for the shared 32-bit datapath bus. It accepts one transfer command at a time over a valid/ready handshake. It then drives the one-hot source out-enables of the bus multiplexer, plus the matching register load enables, one bus step per cycle. The bus therefore never has more than one driver. It sits between the control unit and the bus/register file, and sequences plain moves and two-operand ALU transfers through Y and Z.

## Interface
- No parameters; bus width 32 and source code space 0..23 are fixed.
- Source/destination code map: 0–15 = R0–R15, 16 = HI, 17 = LO, 18 = Zhigh, 19 = Zlow, 20 = PC, 21 = MDR, 22 = InPort, 23 = C.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_alu  input  1  0 = move, 1 = ALU transfer.
- cmd_wide  input  1  ALU result is 64-bit (mul/div); write Zlow→LO and Zhigh→HI.
- cmd_src  input  5  source code (operand A for ALU).
- cmd_src2  input  5  operand B source code (ALU only).
- cmd_dst  input  5  destination code (ignored when cmd_wide).
- cmd_op  input  5  ALU opcode, passed through.
- hold  input  1  freeze sequencing (memory wait).
- src_oe  output  24  one-hot bus out-enables, bit n = code n.
- dst_ld  output  24  one-hot register load enables, bit n = code n.
- y_ld  output  1  load Y from bus.
- z_ld  output  1  load Z from ALU.
- alu_op  output  5  opcode to ALU, valid only while z_ld = 1, else 0.
- done  output  1  one-cycle pulse on last step of a command.
- err  output  1  one-cycle pulse on rejection of an illegal command.

## Operation
- States: IDLE, MOV, A1, A2, A3, A4.
- cmd_ready = 1 only in IDLE with rst_n high. Handshake = cmd_valid & cmd_ready at a rising edge; all cmd_* fields are latched at that edge.
- Legality checks:
  - Source codes must be ≤ 23.
  - Destination codes must be 0–17, 20 or 21.
  - An illegal code in any used field means the command is accepted, err pulses the next cycle, there are no enables, and the state stays IDLE.
- MOV step (cmd_alu = 0): src_oe[src] = 1 and dst_ld[dst] = 1, then return to IDLE.
- ALU steps (cmd_alu = 1):
  - A1: src_oe[src] = 1, y_ld = 1.
  - A2: src_oe[src2] = 1, alu_op = op, z_ld = 1.
  - A3: src_oe[19] = 1. If not wide, dst_ld[dst] = 1 and the command ends. If wide, dst_ld[17] = 1 and go to A4.
  - A4 (wide only): src_oe[18] = 1, dst_ld[16] = 1, then return to IDLE.
- src == dst in a MOV is legal and produces a single cycle with both bits set.
- Outputs are decoded from state plus latched command. src_oe has at most one bit set in every cycle, and dst_ld has at most one bit set.
- hold = 1: state, latched command and all outputs freeze, including a held done. done is asserted exactly once per command, on the first cycle of the final step. The final step's enables remain asserted while held.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE and cmd_ready, src_oe, dst_ld, y_ld, z_ld, alu_op, done, err are all 0. Latched command is cleared. cmd_ready rises in the first cycle after rst_n deasserts.
- Latency (hold = 0), with handshake at edge k:
  - First step enables are valid in cycle k+1.
  - MOV: 1 step; cmd_ready returns in cycle k+2.
  - ALU: 3 steps; cmd_ready in k+4.
  - Wide ALU: 4 steps; cmd_ready in k+5.
- Back-to-back throughput is one command per (steps + 1) cycles, because the IDLE cycle is mandatory.
- Reset asserted mid-command aborts immediately: all enables drop in the same cycle, with no done.
- hold asserted in IDLE does not block acceptance; the held command starts stepping only when hold = 0.

## Test plan
- Reset: drive rst_n low mid-A2 → all outputs 0 asynchronously. After release, cmd_ready = 1 one cycle later.
- MOV src = 3 (R3), dst = 21 (MDR) → cycle k+1: src_oe = 0x000008, dst_ld = 0x200000, done = 1. Cycle k+2: cmd_ready = 1.
- ALU src = 2, src2 = 5, dst = 7, op = 0x03 → A1: src_oe = 0x4, y_ld = 1. A2: src_oe = 0x20, z_ld = 1, alu_op = 3. A3: src_oe = 0x080000, dst_ld = 0x80, done = 1.
- Wide ALU src = 1, src2 = 4 → A3: src_oe bit 19 with dst_ld bit 17. A4: src_oe bit 18 with dst_ld bit 16 and done. Total 4 active cycles.
- Illegal: MOV dst = 19 → accepted, err = 1 for one cycle, src_oe = dst_ld = 0, no done. Next command is accepted normally.
- hold = 1 for 3 cycles during A2 → outputs stay src_oe[src2] / z_ld for 4 cycles total, A3 follows, done pulses once. The one-hot assertion on src_oe is checked every cycle.
